axis_expand: RTL
================

// Module: axis_expand
// PURPOSE
//  ADC-side counterpart of the DAC narrowing scaler. Takes narrow ADC samples from an AXIS slave
//  bus and left-justifies them into a wide processing word (e.g. 14-bit ADC -> 32-bit PIG), where
//  they feed the phase/frequency logic. Optional offset-binary to two's-complement conversion.
//  Registered, full-throughput AXIS pipeline with backpressure and optional tlast framing.
// PARAMETERS
//  AXIS_TDATA_WIDTH  32  width of both tdata buses
//  IL                13  MSB of the input field in S_AXIS_ADC_tdata
//  IR                0   LSB of the input field
//  OL                31  MSB of the output field in M_AXIS_EXP_tdata
//  OR                0   LSB of the output field
//  SIGNED            1   1: sign-extend above OL; 0: zero-fill above OL
//  OFFSET_BINARY     0   1: invert the input MSB before use (offset-binary ADC)
//  FRAME_LEN         0   tlast on every FRAME_LEN-th output beat; 0 disables tlast
// PORTS
//  clk                  in   1     sole clock; all logic on the rising edge
//  rst                  in   1     synchronous, active-low reset
//  S_AXIS_ADC_tdata     in   AXIS_TDATA_WIDTH  raw ADC word; only [IL:IR] is used
//  S_AXIS_ADC_tvalid    in   1     input sample valid
//  S_AXIS_ADC_tready    out  1     registered ready; no combinational path from M tready
//  M_AXIS_EXP_tdata     out  AXIS_TDATA_WIDTH  expanded sample
//  M_AXIS_EXP_tvalid    out  1     output valid
//  M_AXIS_EXP_tready    in   1     downstream ready
//  M_AXIS_EXP_tlast     out  1     frame marker (0 when FRAME_LEN==0)
// BEHAVIOUR
//  - Width rule: SHIFT = (OL-OR)-(IL-IR) and must be >= 0. Elaborate a $error if it is negative
//    (narrowing belongs to the DAC scaler). IL<AXIS_TDATA_WIDTH and OL<AXIS_TDATA_WIDTH.
//  - Conversion: x = S[IL:IR], MSB inverted if OFFSET_BINARY. Output [OL:OR] = x<<SHIFT
//    (LSBs zero-filled). Bits below OR are 0. Bits above OL are copies of x MSB if SIGNED, else 0.
//  - Handshake: input accepted when tvalid&&tready. Output beat transfers on M tvalid&&tready.
//    tdata/tlast are held stable while tvalid=1 and tready=0.
//  - Pipeline: main output register plus a one-entry skid register.
//    Latency is 1 cycle: a sample accepted in cycle N is valid at the output in cycle N+1 when
//    the output is empty or draining.
//  - Skid behaviour:
//    - S tready = !skid_valid.
//    - When the output stalls while a new sample is accepted, that sample is parked in the skid.
//    - The next output transfer loads the skid into the output register and clears skid_valid.
//    - Sustained throughput is 1 beat/cycle. Order is strictly preserved. No sample is dropped
//      or duplicated.
//  - Simultaneous output transfer and input accept with the skid empty: the output register
//    takes the new sample directly.
//  - Framing: beat counter 0..FRAME_LEN-1 advances on each output transfer and wraps to 0.
//    tlast=1 on the beat where counter==FRAME_LEN-1. tlast is computed when the beat is loaded
//    into the output register and travels with it (through the skid as well).
//  - Reset (rst==0 at a clk edge), including mid-stream:
//    - M tvalid=0, M tdata=0, M tlast=0.
//    - skid_valid=0 and S tready=0 during reset; S tready=1 on the first cycle after reset.
//    - Frame counter=0.
//    - In-flight samples are discarded.
// STRUCTURE
//  - Shared package axis_pkg: the SHIFT computation function and the AXIS beat struct
//    {tdata, tlast}, shared with the DAC scaler.
//  - One sub-module: axis_skid_buffer (parameter WIDTH). Generic registered-ready skid used for
//    the {tdata, tlast} beat.
//  - Top level holds the conversion logic and the frame counter.
// TESTING (IL=13, IR=0, OL=31, OR=0 unless stated)
//  1. SIGNED=1: inputs 0x3FFF, 0x1FFF, 0x2000, 0x0001 with M tready=1 -> 0xFFFC0000, 0x7FFC0000,
//     0x80000000, 0x00040000, each 1 cycle after accept.
//  2. OFFSET_BINARY=1, SIGNED=1: input 0x2000 -> 0x00000000; input 0x0000 -> 0x80000000.
//  3. SIGNED=0, OL=15: input 0x3FFF -> 0x0000FFFC. SIGNED=1, OL=15: input 0x3FFF -> 0xFFFFFFFC.
//  4. Backpressure: stream 0..99 with M tready random at 50%.
//     -> Output sequence is exactly 0..99 shifted.
//     -> S tready never depends combinationally on M tready.
//     -> Throughput is 1/cycle when M tready is held at 1.
//  5. FRAME_LEN=4: 10 output beats -> tlast on beats 4 and 8 only. With a stall on the tlast
//     beat, tlast is held with its data.
//  6. Reset asserted with output and skid both full -> next cycle M tvalid=0, tdata=0;
//     S tready=1 one cycle after release. The counter restarts: first tlast on the 4th
//     post-reset beat.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXIS helpers: beat struct and left-justification shift rule,
// common to the ADC expander and the DAC narrowing scaler.
package axis_pkg;

  localparam int AXIS_W = 32;

  typedef struct packed {
    logic [AXIS_W-1:0] tdata;
    logic              tlast;
  } axis_beat_t;

  // Positive result: the input field widens into the output field by this many bits.
  function automatic int expand_shift(input int il, input int ir, input int ol, input int or_lsb);
    return (ol - or_lsb) - (il - ir);
  endfunction

endpackage

// File: rtl/axis_expand_if.sv
// AXI-Stream bundle with master/slave views.
interface axis_expand_if #(
  parameter int W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Registered-ready pipeline stage: one output register plus one skid entry,
// full throughput, no combinational path from out_ready to in_ready.
module axis_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q, ready_d;
  logic             in_fire;
  logic             out_open;

  always_comb begin
    in_fire      = in_valid && ready_q;
    out_open     = !out_valid_q || out_ready;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;

    if (out_open) begin
      // ready_q is low whenever the skid is occupied, so skid and input never compete
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end

    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/axis_expand.sv
// Left-justifies a narrow ADC field into a wide processing word, with optional
// offset-binary conversion, sign extension and tlast framing.
module axis_expand
  import axis_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int IL               = 13,
  parameter int IR               = 0,
  parameter int OL               = 31,
  parameter int OR               = 0,
  parameter int SIGNED           = 1,
  parameter int OFFSET_BINARY    = 0,
  parameter int FRAME_LEN        = 0
) (
  input  logic           clk,
  input  logic           rst,
  axis_expand_if.slave   s_axis_adc,
  axis_expand_if.master  m_axis_exp
);

  localparam int SHIFT = expand_shift(IL, IR, OL, OR);
  localparam int IW    = IL - IR + 1;
  localparam int OW    = OL - OR + 1;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  if (SHIFT < 0) begin : g_bad_shift
    $error("axis_expand: output field narrower than input field");
  end
  if (IL >= AXIS_TDATA_WIDTH || OL >= AXIS_TDATA_WIDTH) begin : g_bad_range
    $error("axis_expand: field MSB outside tdata");
  end
  if (AXIS_TDATA_WIDTH != AXIS_W) begin : g_bad_width
    $error("axis_expand: tdata width must match the shared beat struct");
  end

  logic [IW-1:0]               x;
  logic [OW-1:0]               field;
  logic [AXIS_TDATA_WIDTH-1:0] word;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        last_beat;
  logic                        in_fire;
  logic                        s_ready;
  axis_beat_t                  in_beat, out_beat;
  logic                        unused_in;

  assign unused_in = ^{s_axis_adc.tdata, s_axis_adc.tlast};

  always_comb begin
    x = s_axis_adc.tdata[IL:IR];
    if (OFFSET_BINARY != 0) x[IW-1] = ~x[IW-1];
    field = OW'(x) << SHIFT;
    word  = '0;
    for (int i = OL + 1; i < AXIS_TDATA_WIDTH; i++) word[i] = (SIGNED != 0) && x[IW-1];
    word[OL:OR] = field;
  end

  // Beats leave in acceptance order with none dropped, so the index assigned at
  // accept is the output beat index; tlast then rides through the skid with its data.
  always_comb begin
    in_fire   = s_axis_adc.tvalid && s_ready;
    last_beat = 1'b0;
    cnt_d     = cnt_q;
    if (FRAME_LEN > 0) begin
      last_beat = (32'(cnt_q) == FRAME_LEN - 1);
      if (in_fire) cnt_d = last_beat ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  always_comb begin
    in_beat.tdata = word;
    in_beat.tlast = last_beat;
  end

  axis_skid_buffer #(
    .WIDTH($bits(axis_beat_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_beat),
    .in_valid (s_axis_adc.tvalid),
    .in_ready (s_ready),
    .out_data (out_beat),
    .out_valid(m_axis_exp.tvalid),
    .out_ready(m_axis_exp.tready)
  );

  assign s_axis_adc.tready = s_ready;
  assign m_axis_exp.tdata  = out_beat.tdata;
  assign m_axis_exp.tlast  = out_beat.tlast;

endmodule
